// File: rtl/spi_link_pkg.sv
`default_nettype none
// ============================================================================
//  spi_link_pkg
//  Shared types and defaults for the SPI load/done link (initiator and responder).
//  Revision: 1.0
// ============================================================================
package spi_link_pkg;

    localparam int SPI_BYTE_W      = 8;
    localparam int SPI_NBYTES_DEF  = 4;
    localparam int SPI_SCK_DIV_DEF = 4;
    localparam int SPI_TIMEOUT_DEF = 2048;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_WAIT_CLR  = 3'd5
    } init_state_t;

endpackage : spi_link_pkg
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// ============================================================================
//  spi_sck_gen
//  SPI clock divider: toggles sck every SCK_DIV cycles while enabled and gives
//  single-cycle strobes for the edge about to occur. Idles low when disabled.
//  Revision: 1.0
// ============================================================================
module spi_sck_gen
    import spi_link_pkg::*;
#(
    parameter int SCK_DIV = SPI_SCK_DIV_DEF
) (
    input  logic i_int_osc,
    input  logic i_reset,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int                c_DIV_W  = $clog2(SCK_DIV + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_TC = c_DIV_W'(SCK_DIV - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_sck;
    logic               w_tc;

    assign w_tc   = i_en && (r_div_cnt == c_DIV_TC);
    // Strobes flag the edge that sck takes at the coming clock edge.
    assign o_rise = w_tc && !r_sck;
    assign o_fall = w_tc &&  r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge i_int_osc) begin
        if (!i_reset || !i_en) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule : spi_sck_gen
`default_nettype wire

// File: rtl/spi_load_initiator.sv
`default_nettype none
// ============================================================================
//  spi_load_initiator
//  Initiator end of the SPI load/done link: shifts NBYTES bytes out (mode 0,
//  MSB first) under load, then waits for the responder's done handshake.
//  Optional abort of the done wait is enabled by defining SPI_LOAD_TIMEOUT_EN.
//  Revision: 1.0
// ============================================================================
module spi_load_initiator
    import spi_link_pkg::*;
#(
    parameter int NBYTES  = SPI_NBYTES_DEF,
    parameter int SCK_DIV = SPI_SCK_DIV_DEF,
    parameter int TIMEOUT = SPI_TIMEOUT_DEF
) (
    input  logic                  i_int_osc,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [SPI_BYTE_W-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_sck,
    output logic                  o_sdo,
    output logic                  o_load,
    input  logic                  i_done_in,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_timeout_err
);

    localparam int                  c_BYTE_CNT_W = $clog2(NBYTES + 1);
    localparam logic [c_BYTE_CNT_W-1:0] c_LAST_BYTE = c_BYTE_CNT_W'(NBYTES - 1);
    localparam logic [3:0]          c_LAST_BIT   = 4'(SPI_BYTE_W - 1);

    init_state_t             r_state;
    init_state_t             w_state_nxt;
    logic [SPI_BYTE_W-1:0]   r_sreg;
    logic [3:0]              r_bit_cnt;
    logic [c_BYTE_CNT_W-1:0] r_byte_cnt;
    logic                    r_load;
    logic                    r_done_m;
    logic                    r_done_s;
    logic                    r_frame_done;
    logic                    r_timeout_err;
    logic                    w_shift_en;
    logic                    w_sck_rise;
    logic                    w_sck_fall;
    logic                    w_byte_end;
    logic                    w_last_byte;
    logic                    w_to_hit;
    logic                    w_unused_rise;

    assign w_shift_en  = (r_state == ST_SHIFT);
    assign w_byte_end  = w_shift_en && w_sck_fall && (r_bit_cnt == c_LAST_BIT);
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
    assign w_unused_rise = w_sck_rise;

    spi_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .i_int_osc (i_int_osc),
        .i_reset   (i_reset),
        .i_en      (w_shift_en),
        .o_sck     (o_sck),
        .o_rise    (w_sck_rise),
        .o_fall    (w_sck_fall)
    );

`ifdef SPI_LOAD_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    always_ff @(posedge i_int_osc) begin
        if (!i_reset) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_RELEASE) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_WAIT_DONE) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // A done arriving on the terminal cycle takes priority over the abort.
    assign w_to_hit = (r_state == ST_WAIT_DONE) && !r_done_s
                   && (r_to_cnt == 32'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_to_hit         = 1'b0;
`endif

    always_ff @(posedge i_int_osc) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_tx_ready  = 1'b0;
        o_busy      = 1'b1;
        o_sdo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_tx_ready = 1'b1;
                if (i_tx_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_sdo = r_sreg[SPI_BYTE_W-1];
                if (w_byte_end) begin
                    w_state_nxt = w_last_byte ? ST_RELEASE : ST_FETCH;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (r_done_s) begin
                    w_state_nxt = ST_WAIT_CLR;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_CLR: begin
                // Only a fresh low on done closes the frame, so a stale high
                // level is never credited to the next frame.
                if (!r_done_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_int_osc) begin
        if (!i_reset) begin
            r_done_m <= 1'b0;
            r_done_s <= 1'b0;
        end else begin
            r_done_m <= i_done_in;
            r_done_s <= r_done_m;
        end
    end

    always_ff @(posedge i_int_osc) begin
        if (!i_reset) begin
            r_sreg        <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_load        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_frame_done  <= (r_state == ST_WAIT_CLR) && !r_done_s;
            r_timeout_err <= w_to_hit;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_load     <= 1'b1;
                        r_byte_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (i_tx_valid) begin
                        r_sreg    <= i_tx_data;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_sck_fall) begin
                        r_sreg    <= {r_sreg[SPI_BYTE_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == c_LAST_BIT && !w_last_byte) begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_load <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_load        = r_load;
    assign o_frame_done  = r_frame_done;
    assign o_timeout_err = r_timeout_err;

endmodule : spi_load_initiator
`default_nettype wire

// File: tb/tb_spi_load_initiator.sv
`default_nettype none
// ============================================================================
//  tb_spi_load_initiator
//  Randomized self-checking bench: serial bits, load/frame_done timing and the
//  done handshake are checked against a frame-level reference model.
//  Revision: 1.0
// ============================================================================
module tb_spi_load_initiator;

    localparam int NB  = 2;
    localparam int DIV = 2;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       done_in = 1'b0;
    logic       tx_ready, sck, sdo, load, busy, frame_done, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_load_initiator #(
        .NBYTES  (NB),
        .SCK_DIV (DIV),
        .TIMEOUT (TO)
    ) dut (
        .i_int_osc     (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_sck         (sck),
        .o_sdo         (sdo),
        .o_load        (load),
        .i_done_in     (done_in),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_timeout_err (timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_neg();
        @(negedge clk);
        #1;
    endtask

    // Line monitor: captures sdo on each sck rise and records pin events.
    bit   rx_bits[$];
    int   cyc = 0, n_rise = 0, fd_cnt = 0, te_cnt = 0, fetch_cnt = 0;
    int   last_fall_cyc = 0, load_fall_cyc = 0;
    logic prev_sck = 1'b0, prev_load = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (!prev_sck && sck) begin
                rx_bits.push_back(sdo);
                n_rise++;
            end
            if (prev_sck && !sck) last_fall_cyc = cyc;
            if (prev_load && !load) load_fall_cyc = cyc;
            if (frame_done) fd_cnt++;
            if (timeout_err) te_cnt++;
            if (tx_ready) begin
                fetch_cnt++;
                check_eq("fetch_pins", {30'd0, load, sck}, 32'd2);
            end
        end
        prev_sck  = sck;
        prev_load = load;
    end

    // Byte source: gap < 0 gives random spacing, gap > 0 stalls that many
    // cycles beyond one byte time, gap == 0 keeps valid high.
    logic [7:0] src_q[$];
    int         gap_cfg = 0;
    int         stall = 0;
    bit         src_en = 1'b1;
    bit         src_hs = 1'b0;

    initial forever begin
        @(negedge clk);
        src_hs = tx_valid && tx_ready;
        @(posedge clk);
        #1;
        if (src_hs && src_q.size() > 0) begin
            void'(src_q.pop_front());
            if (gap_cfg < 0)       stall = $urandom_range(0, 40);
            else if (gap_cfg == 0) stall = 0;
            else                   stall = 16 * DIV + gap_cfg;
        end
        if (!src_en) begin
            tx_valid = 1'b0;
        end else if (stall > 0) begin
            stall--;
            tx_valid = 1'b0;
        end else if (src_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = src_q[0];
        end else begin
            tx_valid = 1'b0;
        end
    end

    task automatic run_frame(input logic [15:0] bytes, input int gap, input bit stray,
                             input bit stale, input bit exp_to, input int dly, input int len);
        int         base_fd, base_te, k;
        bit         stray_sent, stale_dropped;
        logic [7:0] exp_b[NB];
        logic [7:0] got;
        exp_b[0] = bytes[15:8];
        exp_b[1] = bytes[7:0];
        gap_cfg = gap;
        rx_bits.delete();
        n_rise = 0;
        fetch_cnt = 0;
        base_fd = fd_cnt;
        base_te = te_cnt;
        stray_sent = 1'b0;
        stale_dropped = 1'b0;
        for (int i = 0; i < NB; i++) src_q.push_back(exp_b[i]);
        if (stale) begin
            @(posedge clk); #1 done_in = 1'b1;
            repeat (5) @(posedge clk);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_eq("load_start", {31'd0, load}, 32'd1);
        check_eq("busy_start", {31'd0, busy}, 32'd1);
        k = 0;
        while (load && k < 5000) begin
            tick_neg();
            k++;
            if (stray && !stray_sent && n_rise >= 3) begin
                start = 1'b1;
                tick_neg();
                start = 1'b0;
                stray_sent = 1'b1;
            end
            if (stale && !stale_dropped && n_rise >= 8) begin
                check_eq("stale_hold", fd_cnt - base_fd, 0);
                done_in = 1'b0;
                stale_dropped = 1'b1;
            end
        end
        check_eq("load_fall", {31'd0, load}, 32'd0);
        check_eq("rises", n_rise, NB * 8);
        for (int i = 0; i < NB; i++) begin
            got = 8'h00;
            for (int j = 0; j < 8; j++)
                got = {got[6:0], (8 * i + j < rx_bits.size()) ? rx_bits[8 * i + j] : 1'b0};
            check_eq($sformatf("byte%0d", i), {24'd0, got}, {24'd0, exp_b[i]});
        end
        check_eq("load_lat", load_fall_cyc - last_fall_cyc, 1);
        check_eq("sdo_rel", {31'd0, sdo}, 32'd0);
        if (gap >= 50) check_eq("stall_seen", {31'd0, fetch_cnt >= 50}, 32'd1);
        check_eq("fd_early", fd_cnt - base_fd, 0);
        if (exp_to) begin
            k = 0;
            do begin
                tick_neg();
                k++;
            end while (!timeout_err && k < 500);
            check_eq("to_lat", k, TO);
            check_eq("busy_to", {31'd0, busy}, 32'd0);
            check_eq("fd_to", fd_cnt - base_fd, 0);
            return;
        end
        repeat (20 + dly) tick_neg();
        check_eq("fd_wait", fd_cnt - base_fd, 0);
        check_eq("busy_wait", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 done_in = 1'b1;
        repeat (len) @(posedge clk);
        #1 done_in = 1'b0;
        k = 0;
        do begin
            tick_neg();
            k++;
        end while (!frame_done && k < 20);
        check_eq("fd_lat", k, 4);
        check_eq("busy_end", {31'd0, busy}, 32'd0);
        tick_neg();
        check_eq("fd_pulse", {31'd0, frame_done}, 32'd0);
        check_eq("fd_count", fd_cnt - base_fd, 1);
        check_eq("te_none", te_cnt - base_te, 0);
        if (stray) begin
            repeat (30) tick_neg();
            check_eq("no_refire", {31'd0, busy}, 32'd0);
            check_eq("fd_single", fd_cnt - base_fd, 1);
        end
    endtask

    task automatic reset_mid_frame();
        int k, base_fd, base_te;
        src_q.push_back(8'h5A);
        src_q.push_back(8'hC3);
        gap_cfg = 0;
        n_rise = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (n_rise < 3 && k < 500) begin
            tick_neg();
            k++;
        end
        check_eq("pre_rst_load", {31'd0, load}, 32'd1);
        base_fd = fd_cnt;
        base_te = te_cnt;
        @(posedge clk); #1 rst_n = 1'b0;
        src_en = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_pins", {29'd0, load, sck, busy}, 32'd0);
        repeat (2) @(posedge clk);
        src_q.delete();
        stall = 0;
        #1 rst_n = 1'b1;
        src_en = 1'b1;
        repeat (40) tick_neg();
        check_eq("rst_no_pulse", (fd_cnt - base_fd) + (te_cnt - base_te), 0);
        check_eq("rst_idle", {30'd0, busy, load}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_outs", {25'd0, tx_ready, sck, sdo, load, busy, frame_done, timeout_err}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_frame(16'hA53C, 0, 1'b0, 1'b0, 1'b0, 0, 10);
        run_frame(16'($urandom), 50, 1'b0, 1'b0, 1'b0, 5, 3);
        run_frame(16'($urandom), 0, 1'b0, 1'b1, 1'b0, 0, 6);
        run_frame(16'($urandom), -1, 1'b1, 1'b0, 1'b0, 2, 1);
        reset_mid_frame();
`ifdef SPI_LOAD_TIMEOUT_EN
        run_frame(16'($urandom), 0, 1'b0, 1'b0, 1'b1, 0, 0);
`else
        run_frame(16'($urandom), 0, 1'b0, 1'b0, 1'b0, 300, 4);
`endif
        for (int f = 0; f < 8; f++)
            run_frame(16'($urandom), -1, bit'($urandom_range(0, 1)), 1'b0, 1'b0,
                      $urandom_range(0, 30), $urandom_range(1, 12));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spi_load_initiator
`default_nettype wire
